// File: rtl/dff_pipeline.sv
// Elastic WIDTH x DEPTH register pipeline with per-stage valid bits, valid/ready
// handshakes, bubble collapsing, synchronous flush and an occupancy count.
module dff_pipeline #(
  parameter int                WIDTH     = 8,
  parameter int                DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           Data,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic                       Flush,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Qb,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] data_r;
  logic [DEPTH-1:0]            valid_r;
  logic [CW-1:0]               count_r;
  logic [DEPTH-1:0]            move_s;
  logic                        in_ready_s;
  logic                        accept_s;

  // A word moves when the stage ahead is empty or itself emptying; this is
  // what closes bubbles while the output is stalled.
  assign move_s[DEPTH-1] = valid_r[DEPTH-1] & OutReady;

  for (genvar i = 0; i < DEPTH-1; i++) begin : g_move
    assign move_s[i] = valid_r[i] & (~valid_r[i+1] | move_s[i+1]);
  end

  assign in_ready_s = ~Flush & (~valid_r[0] | move_s[0]);
  assign accept_s   = InValid & in_ready_s;

  // Stage registers, valid bits and occupancy count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      data_r  <= {DEPTH{RESET_VAL}};
      valid_r <= {DEPTH{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (Flush) begin
      data_r  <= {DEPTH{RESET_VAL}};
      valid_r <= {DEPTH{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (accept_s) begin
        data_r[0]  <= Data;
        valid_r[0] <= 1'b1;
      end else if (move_s[0]) begin
        valid_r[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        // Empty stages keep their old data; only the valid bit drops.
        if (move_s[i-1]) begin
          data_r[i]  <= data_r[i-1];
          valid_r[i] <= 1'b1;
        end else if (move_s[i]) begin
          valid_r[i] <= 1'b0;
        end
      end
      count_r <= count_r + CW'(accept_s) - CW'(move_s[DEPTH-1]);
    end
  end

  assign InReady  = in_ready_s;
  assign Q        = data_r[DEPTH-1];
  assign Qb       = ~data_r[DEPTH-1];
  assign OutValid = valid_r[DEPTH-1];
  assign Count    = count_r;

endmodule

// File: tb/tb_dff_pipeline.sv
// Self-checking bench for dff_pipeline: a positional queue model for the
// default 8x4 instance and directed checks on a 1x1 instance.
module tb_dff_pipeline;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RVAL = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic             reset_a = 1'b1, flush_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic [WIDTH-1:0] data_a = 8'h00;
  logic             in_ready_a, out_valid_a;
  logic [WIDTH-1:0] q_a, qb_a;
  logic [2:0]       count_a;

  dff_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RVAL)) dut_a (
    .Clock(clk), .Reset(reset_a), .Data(data_a), .InValid(in_valid_a),
    .InReady(in_ready_a), .Flush(flush_a), .Q(q_a), .Qb(qb_a),
    .OutValid(out_valid_a), .OutReady(out_ready_a), .Count(count_a)
  );

  // DEPTH = 1, WIDTH = 1 instance
  logic       reset_b = 1'b1, flush_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [0:0] data_b = 1'b0;
  logic       in_ready_b, out_valid_b;
  logic [0:0] q_b, qb_b;
  logic [0:0] count_b;

  dff_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut_b (
    .Clock(clk), .Reset(reset_b), .Data(data_b), .InValid(in_valid_b),
    .InReady(in_ready_b), .Flush(flush_b), .Q(q_b), .Qb(qb_b),
    .OutValid(out_valid_b), .OutReady(out_ready_b), .Count(count_b)
  );

  int checks = 0;
  int failures = 0;

  // Model: words in arrival order with their stage index (DEPTH = left).
  int               pos_q[$];
  logic [WIDTH-1:0] val_q[$];
  logic [WIDTH-1:0] last_q = RVAL;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [WIDTH-1:0] d, input logic v, input logic ordy,
                      input logic fl, input logic rs);
    int   np[$];
    int   lim;
    int   nxt;
    logic rdy_exp;
    logic ov_exp;
    @(negedge clk);
    data_a = d; in_valid_a = v; out_ready_a = ordy; flush_a = fl; reset_a = rs;
    #1;
    // Each word advances one stage unless blocked by the word ahead of it.
    np = {};
    for (int k = 0; k < pos_q.size(); k++) begin
      if (k == 0) lim = (pos_q[0] == DEPTH-1 && ordy) ? DEPTH : DEPTH-1;
      else        lim = np[k-1] - 1;
      nxt = pos_q[k] + 1;
      np.push_back((nxt < lim) ? nxt : lim);
    end
    rdy_exp = !fl && (np.size() == 0 || np[np.size()-1] > 0);
    if (!rs) chk("in_ready", {7'b0, in_ready_a}, {7'b0, rdy_exp});
    @(posedge clk);
    if (rs || fl) begin
      pos_q.delete();
      val_q.delete();
      last_q = RVAL;
    end else begin
      for (int k = 0; k < np.size(); k++)
        if (np[k] == DEPTH-1 && pos_q[k] != DEPTH-1) last_q = val_q[k];
      pos_q = np;
      if (pos_q.size() > 0 && pos_q[0] == DEPTH) begin
        void'(pos_q.pop_front());
        void'(val_q.pop_front());
      end
      if (v && rdy_exp) begin
        pos_q.push_back(0);
        val_q.push_back(d);
      end
    end
    #1;
    ov_exp = (pos_q.size() > 0) && (pos_q[0] == DEPTH-1);
    chk("q", q_a, last_q);
    chk("qb", qb_a, ~last_q);
    chk("out_valid", {7'b0, out_valid_a}, {7'b0, ov_exp});
    chk("count", {5'b0, count_a}, 8'(pos_q.size()));
  endtask

  initial begin
    // Reset held two cycles with a word offered
    step(8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
    step(8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("reset_q", q_a, 8'h00);
    chk("reset_qb", qb_a, 8'hFF);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Latency and streaming
    for (int i = 1; i <= 8; i++) step(8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill and stall, then simultaneous in/out at full
    for (int i = 0; i < 6; i++)  step(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_count", {5'b0, count_a}, 8'd4);
    chk("full_q", q_a, 8'h11);
    for (int i = 0; i < 3; i++)  step(8'h21 + 8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stream_full_count", {5'b0, count_a}, 8'd4);
    for (int i = 0; i < 6; i++)  step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Bubble collapse
    step(8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h32, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bubble_count", {5'b0, count_a}, 8'd2);
    for (int i = 0; i < 3; i++)  step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Flush with three words inside
    for (int i = 0; i < 3; i++)  step(8'h41 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_count", {5'b0, count_a}, 8'd0);
    for (int i = 0; i < 5; i++)  step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional flush/reset and stall phases
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] d;
      logic v, ordy, fl, rs;
      d    = 8'($urandom);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      rs   = ($urandom_range(0, 99) == 0);
      step(d, v, ordy, fl, rs);
    end

    // DEPTH = 1, WIDTH = 1 instance
    @(negedge clk); reset_b = 1'b1;
    @(posedge clk); #1;
    chk("b_reset_q", {7'b0, q_b}, 8'd0);
    chk("b_reset_ov", {7'b0, out_valid_b}, 8'd0);
    chk("b_reset_count", {7'b0, count_b}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset_b = 1'b0; data_b = 1'(i & 1); in_valid_b = 1'b1; out_ready_b = 1'b1;
      #1;
      chk("b_stream_ready", {7'b0, in_ready_b}, 8'd1);
      @(posedge clk); #1;
      chk("b_stream_q", {7'b0, q_b}, {7'b0, data_b});
      chk("b_stream_qb", {7'b0, qb_b}, {7'b0, ~data_b});
      chk("b_stream_ov", {7'b0, out_valid_b}, 8'd1);
    end
    @(negedge clk); in_valid_b = 1'b0; out_ready_b = 1'b1;
    @(posedge clk); #1;
    chk("b_drain_ov", {7'b0, out_valid_b}, 8'd0);
    @(negedge clk); data_b = 1'b1; in_valid_b = 1'b1; out_ready_b = 1'b0;
    #1;
    chk("b_empty_ready", {7'b0, in_ready_b}, 8'd1);
    @(posedge clk); #1;
    chk("b_hold_q0", {7'b0, q_b}, 8'd1);
    @(negedge clk); data_b = 1'b0;
    #1;
    chk("b_full_ready", {7'b0, in_ready_b}, 8'd0);
    @(posedge clk); #1;
    chk("b_hold_q1", {7'b0, q_b}, 8'd1);
    chk("b_hold_qb", {7'b0, qb_b}, 8'd0);
    chk("b_hold_count", {7'b0, count_b}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
